// File: rtl/mini16sc_dmem_io_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mini16sc_dmem_io_pkg : I/O window map and STATUS layout              |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package mini16sc_dmem_io_pkg;

  localparam int WIN_BITS    = 3;
  localparam int WINDOW_SIZE = 1 << WIN_BITS;

  typedef enum logic [WIN_BITS-1:0] {
    OFS_TX_PUSH = 3'd0,
    OFS_RX_DATA = 3'd1,
    OFS_RX_POP  = 3'd2,
    OFS_STATUS  = 3'd3,
    OFS_CYCLE   = 3'd4
  } io_ofs_e;

  localparam int STS_RX_NOT_EMPTY = 0;
  localparam int STS_TX_NOT_FULL  = 1;
  localparam int STS_TX_OVERFLOW  = 2;
  localparam int STS_RX_UNDERFLOW = 3;
  localparam int STS_RX_COUNT_LSB = 8;

endpackage
`default_nettype wire

// File: rtl/mini16sc_sync_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mini16sc_sync_fifo : first-word-fall-through FIFO, registered head   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module mini16sc_sync_fifo #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_BITS:0]   count,
  output logic [WIDTH-1:0]      head
);

  localparam logic [DEPTH_BITS:0] FULL_COUNT = (DEPTH_BITS+1)'(1 << DEPTH_BITS);

  logic [WIDTH-1:0]      mem [1 << DEPTH_BITS];
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_next;
  logic [DEPTH_BITS:0]   remain;
  logic                  do_pop;
  logic                  do_push;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees a slot in the same cycle, so a push while full still lands.
  assign do_push = push & (~full | do_pop);
  assign rd_next = rd_ptr + DEPTH_BITS'(do_pop);
  assign remain  = count - (DEPTH_BITS+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      rd_ptr <= rd_next;
      wr_ptr <= wr_ptr + DEPTH_BITS'(do_push);
      count  <= remain + (DEPTH_BITS+1)'(do_push);
      // Next head comes from storage unless the FIFO drains to nothing this edge.
      if (remain != '0)  head <= mem[rd_next];
      else if (do_push)  head <= push_data;
      else               head <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mini16sc_dmem_io.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mini16sc_dmem_io : data RAM plus TX/RX FIFO memory-mapped I/O window |
// | Option: MINI16SC_DMEM_IO_CYCLE_COUNTER_EN adds a counter at BASE+4   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module mini16sc_dmem_io
  import mini16sc_dmem_io_pkg::*;
#(
  parameter int WIDTH_D    = 16,
  parameter int DEPTH_D    = 8,
  parameter int FIFO_DEPTH = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DEPTH_D-1:0] mem_d_r_addr,
  output logic [WIDTH_D-1:0] mem_d_r_data,
  input  logic [DEPTH_D-1:0] mem_d_w_addr,
  input  logic [WIDTH_D-1:0] mem_d_w_data,
  input  logic               mem_d_we,
  output logic [WIDTH_D-1:0] tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  logic [WIDTH_D-1:0] rx_data,
  input  logic               rx_valid,
  output logic               rx_ready
);

  localparam int RAM_WORDS = (1 << DEPTH_D) - WINDOW_SIZE;
  localparam logic [FIFO_DEPTH:0] FIFO_FULL = (FIFO_DEPTH+1)'(1 << FIFO_DEPTH);

  logic [WIDTH_D-1:0]  ram [RAM_WORDS];

  logic                w_win;
  logic                r_win;
  logic [WIN_BITS-1:0] w_ofs;
  logic [WIN_BITS-1:0] r_ofs;
  logic                tx_push_wr;
  logic                rx_pop_wr;
  logic                status_wr;

  logic                tx_full;
  logic                tx_empty;
  logic [FIFO_DEPTH:0] tx_count;
  logic [WIDTH_D-1:0]  tx_head;
  logic                rx_full;
  logic                rx_empty;
  logic [FIFO_DEPTH:0] rx_count;
  logic [WIDTH_D-1:0]  rx_head;
  logic                rx_push;
  logic                rx_pop_ok;
  logic [FIFO_DEPTH:0] rx_count_nxt;

  logic                tx_overflow;
  logic                rx_underflow;
  logic                overflow_set;
  logic                underflow_set;
  logic [WIDTH_D-1:0]  status;
  logic [WIDTH_D-1:0]  cycle_val;
  logic [WIDTH_D-1:0]  rd_val;

  assign w_win      = &mem_d_w_addr[DEPTH_D-1:WIN_BITS];
  assign r_win      = &mem_d_r_addr[DEPTH_D-1:WIN_BITS];
  assign w_ofs      = mem_d_w_addr[WIN_BITS-1:0];
  assign r_ofs      = mem_d_r_addr[WIN_BITS-1:0];
  assign tx_push_wr = mem_d_we & w_win & (w_ofs == OFS_TX_PUSH);
  assign rx_pop_wr  = mem_d_we & w_win & (w_ofs == OFS_RX_POP);
  assign status_wr  = mem_d_we & w_win & (w_ofs == OFS_STATUS);

  mini16sc_sync_fifo #(.WIDTH(WIDTH_D), .DEPTH_BITS(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push_wr),
    .push_data (mem_d_w_data),
    .pop       (tx_ready),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count),
    .head      (tx_head)
  );

  mini16sc_sync_fifo #(.WIDTH(WIDTH_D), .DEPTH_BITS(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_push),
    .push_data (rx_data),
    .pop       (rx_pop_wr),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count),
    .head      (rx_head)
  );

  assign tx_data       = tx_head;
  assign tx_valid      = ~tx_empty;
  assign rx_push       = rx_valid & rx_ready & ~rx_full;
  assign rx_pop_ok     = rx_pop_wr & ~rx_empty;
  assign rx_count_nxt  = rx_count + (FIFO_DEPTH+1)'(rx_push) - (FIFO_DEPTH+1)'(rx_pop_ok);
  assign overflow_set  = tx_push_wr & tx_full & ~tx_ready;
  assign underflow_set = rx_pop_wr & rx_empty;

  // rx_ready tracks the post-edge fill level so a full FIFO never sees a capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ready     <= 1'b0;
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      rx_ready     <= (rx_count_nxt != FIFO_FULL);
      tx_overflow  <= (tx_overflow  & ~(status_wr & mem_d_w_data[STS_TX_OVERFLOW]))  | overflow_set;
      rx_underflow <= (rx_underflow & ~(status_wr & mem_d_w_data[STS_RX_UNDERFLOW])) | underflow_set;
    end
  end

`ifdef MINI16SC_DMEM_IO_CYCLE_COUNTER_EN
  logic               cycle_wr;
  logic [WIDTH_D-1:0] cycle_cnt;

  assign cycle_wr  = mem_d_we & w_win & (w_ofs == OFS_CYCLE);
  assign cycle_val = cycle_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         cycle_cnt <= '0;
    else if (cycle_wr) cycle_cnt <= mem_d_w_data;
    else               cycle_cnt <= cycle_cnt + WIDTH_D'(1);
  end
`else
  assign cycle_val = '0;
`endif

  always_comb begin
    status = '0;
    status[STS_RX_NOT_EMPTY] = ~rx_empty;
    status[STS_TX_NOT_FULL]  = (tx_count != FIFO_FULL);
    status[STS_TX_OVERFLOW]  = tx_overflow;
    status[STS_RX_UNDERFLOW] = rx_underflow;
    status[STS_RX_COUNT_LSB +: FIFO_DEPTH+1] = rx_count;
  end

  always_comb begin
    rd_val = '0;
    if (!r_win) begin
      rd_val = ram[mem_d_r_addr];
    end else begin
      case (r_ofs)
        OFS_RX_DATA: rd_val = rx_empty ? '0 : rx_head;
        OFS_STATUS:  rd_val = status;
        OFS_CYCLE:   rd_val = cycle_val;
        default:     rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_d_we && !w_win) ram[mem_d_w_addr] <= mem_d_w_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mem_d_r_data <= '0;
    else       mem_d_r_data <= rd_val;
  end

endmodule
`default_nettype wire

// File: tb/tb_mini16sc_dmem_io.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mini16sc_dmem_io : randomized + directed bench with queue model   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_mini16sc_dmem_io;

  localparam int BASE = 248;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  mem_d_r_addr = '0;
  logic [15:0] mem_d_r_data;
  logic [7:0]  mem_d_w_addr = '0;
  logic [15:0] mem_d_w_data = '0;
  logic        mem_d_we = 1'b0;
  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;

  always #5 clk = ~clk;

  mini16sc_dmem_io dut (
    .clk          (clk),
    .reset        (reset),
    .mem_d_r_addr (mem_d_r_addr),
    .mem_d_r_data (mem_d_r_data),
    .mem_d_w_addr (mem_d_w_addr),
    .mem_d_w_data (mem_d_w_data),
    .mem_d_we     (mem_d_we),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready)
  );

  // Reference model: queues for the FIFOs, an array for RAM, plain flags.
  logic [15:0] q_tx[$];
  logic [15:0] q_rx[$];
  logic [15:0] ram_m [0:BASE-1];
  bit          ovf_m;
  bit          unf_m;
  logic [15:0] cyc_m;
  logic [15:0] exp_rdata;
  bit          exp_rx_ready;
  int          checks = 0;
  int          errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_tx.delete();
    q_rx.delete();
    ovf_m = 0;
    unf_m = 0;
    cyc_m = '0;
    exp_rdata = '0;
    exp_rx_ready = 0;
  endtask

  function automatic logic [15:0] read_model(logic [7:0] a);
    logic [15:0] s;
    int n;
    s = '0;
    if (int'(a) < BASE) return ram_m[a];
    case (int'(a) - BASE)
      1: return (q_rx.size() > 0) ? q_rx[0] : 16'h0000;
      3: begin
        n = q_rx.size();
        s[0] = (q_rx.size() > 0);
        s[1] = (q_tx.size() < 8);
        s[2] = ovf_m;
        s[3] = unf_m;
        s[11:8] = n[3:0];
        return s;
      end
`ifdef MINI16SC_DMEM_IO_CYCLE_COUNTER_EN
      4: return cyc_m;
`endif
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_edge();
    bit win;
    int ofs;
    bit cap;
    exp_rdata = read_model(mem_d_r_addr);
    win = (int'(mem_d_w_addr) >= BASE);
    ofs = int'(mem_d_w_addr) - BASE;
    cap = rx_valid && exp_rx_ready;
    cyc_m = cyc_m + 16'd1;
    if (tx_ready && q_tx.size() > 0) void'(q_tx.pop_front());
    if (mem_d_we) begin
      if (!win) ram_m[mem_d_w_addr] = mem_d_w_data;
      else case (ofs)
        0: if (q_tx.size() < 8) q_tx.push_back(mem_d_w_data); else ovf_m = 1;
        2: if (q_rx.size() == 0) unf_m = 1; else void'(q_rx.pop_front());
        3: begin
          if (mem_d_w_data[2]) ovf_m = 0;
          if (mem_d_w_data[3]) unf_m = 0;
        end
`ifdef MINI16SC_DMEM_IO_CYCLE_COUNTER_EN
        4: cyc_m = mem_d_w_data;
`endif
        default: ;
      endcase
    end
    if (cap) q_rx.push_back(rx_data);
    exp_rx_ready = (q_rx.size() < 8);
  endtask

  // Compare process: model advances on each edge, outputs checked 1 time unit later.
  always @(posedge clk) begin
    if (!reset) model_edge();
    #1;
    if (!reset) begin
      check("r_data", 32'(mem_d_r_data), 32'(exp_rdata));
      check("tx_valid", 32'(tx_valid), 32'(q_tx.size() > 0));
      if (q_tx.size() > 0) check("tx_data", 32'(tx_data), 32'(q_tx[0]));
      check("rx_ready", 32'(rx_ready), 32'(exp_rx_ready));
    end
  end

  task automatic cyc(bit we, logic [7:0] wa, logic [15:0] wd, logic [7:0] ra,
                     bit txr, bit rxv, logic [15:0] rxd);
    @(negedge clk);
    mem_d_we = we;
    mem_d_w_addr = wa;
    mem_d_w_data = wd;
    mem_d_r_addr = ra;
    tx_ready = txr;
    rx_valid = rxv;
    rx_data = rxd;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("rst_r_data", 32'(mem_d_r_data), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_rx_ready", 32'(rx_ready), 32'h0);
    @(negedge clk);
    @(negedge clk);
    mem_d_we = 1'b0;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    mem_d_r_addr = 8'(BASE + 3);
    reset = 1'b0;
    @(posedge clk);
    #2;
    check("rel_rx_ready", 32'(rx_ready), 32'h1);
    check("rel_status", 32'(mem_d_r_data), 32'h0002);
  endtask

  function automatic logic [7:0] pick_addr();
    if ($urandom_range(0, 1) == 1) return 8'(BASE + int'($urandom_range(0, 7)));
    return 8'($urandom_range(0, BASE - 1));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  S;
    logic [7:0]  wa;
    logic [7:0]  ra;
    logic [15:0] wd;
    bit          we;
    S = 8'(BASE + 3);
    model_reset();
    do_reset();

    // Fill RAM so every random read has a known expected value.
    for (int a = 0; a < BASE; a++) cyc(1, 8'(a), 16'($urandom), S, 0, 0, 0);

    // TX basic
    cyc(1, 8'(BASE), 16'h1234, S, 0, 0, 0);
    cyc(1, 8'(BASE), 16'hBEEF, S, 0, 0, 0);
    check("tx_first_lit", 32'(tx_data), 32'h1234);
    check("tx_valid_lit", 32'(tx_valid), 32'h1);
    cyc(0, 0, 0, S, 1, 0, 0);
    check("tx_second_lit", 32'(tx_data), 32'hBEEF);
    cyc(0, 0, 0, S, 1, 0, 0);
    check("tx_drained_lit", 32'(tx_valid), 32'h0);

    // Reset in the middle of a transfer discards FIFO contents
    for (int i = 0; i < 3; i++) cyc(1, 8'(BASE), 16'(i + 16'h40), S, 0, 0, 0);
    do_reset();
    check("rst_tx_empty", 32'(tx_valid), 32'h0);

    // TX overflow
    for (int i = 0; i < 9; i++) cyc(1, 8'(BASE), 16'(i), S, 0, 0, 0);
    cyc(0, 0, 0, S, 0, 0, 0);
    check("ovf_status_lit", 32'(mem_d_r_data), 32'h0004);
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain_lit", 32'(tx_data), 32'(i));
      cyc(0, 0, 0, S, 1, 0, 0);
    end
    check("ovf_empty_lit", 32'(tx_valid), 32'h0);
    cyc(1, S, 16'h0004, S, 0, 0, 0);
    cyc(0, 0, 0, S, 0, 0, 0);
    check("ovf_clear_lit", 32'(mem_d_r_data), 32'h0002);

    // RX fill, rx_ready must fall after the eighth capture
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, S, 0, 1, 16'(16'hA0 + i));
    check("rx_full_ready_lit", 32'(rx_ready), 32'h0);
    cyc(0, 0, 0, S, 0, 1, 16'hEE);
    check("rx_count8_lit", 32'(mem_d_r_data), 32'h0803);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 8'(BASE + 1), 0, 0, 0);
      check("rx_order_lit", 32'(mem_d_r_data), 32'(16'hA0 + i));
      cyc(1, 8'(BASE + 2), 16'h0, 8'(BASE + 1), 0, 0, 0);
    end

    // RX pop on empty together with a capture
    cyc(1, 8'(BASE + 2), 16'h0, S, 0, 1, 16'h0055);
    cyc(0, 0, 0, S, 0, 0, 0);
    check("unf_status_lit", 32'(mem_d_r_data), 32'h010B);
    cyc(0, 0, 0, 8'(BASE + 1), 0, 0, 0);
    check("unf_rxdata_lit", 32'(mem_d_r_data), 32'h0055);
    cyc(1, 8'(BASE + 2), 16'h0, S, 0, 0, 0);
    cyc(1, S, 16'h0008, S, 0, 0, 0);

    // RAM / window isolation
    cyc(1, 8'h10, 16'h7777, S, 0, 0, 0);
    cyc(1, 8'(BASE + 5), 16'h1111, 8'h10, 0, 0, 0);
    check("ram_lit", 32'(mem_d_r_data), 32'h7777);
    cyc(0, 0, 0, 8'(BASE + 5), 0, 0, 0);
    check("reserved_lit", 32'(mem_d_r_data), 32'h0000);

`ifdef MINI16SC_DMEM_IO_CYCLE_COUNTER_EN
    cyc(1, 8'(BASE + 4), 16'hFFFE, S, 0, 0, 0);
    cyc(0, 0, 0, 8'(BASE + 4), 0, 0, 0);
    check("cyc_fffe_lit", 32'(mem_d_r_data), 32'hFFFE);
    cyc(0, 0, 0, 8'(BASE + 4), 0, 0, 0);
    check("cyc_ffff_lit", 32'(mem_d_r_data), 32'hFFFF);
    cyc(0, 0, 0, 8'(BASE + 4), 0, 0, 0);
    check("cyc_wrap_lit", 32'(mem_d_r_data), 32'h0000);
`else
    cyc(1, 8'(BASE + 4), 16'hFFFE, S, 0, 0, 0);
    cyc(0, 0, 0, 8'(BASE + 4), 0, 0, 0);
    check("cyc_off_lit", 32'(mem_d_r_data), 32'h0000);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      we = ($urandom_range(0, 2) != 0);
      wa = pick_addr();
      ra = pick_addr();
      wd = 16'($urandom);
      cyc(we, wa, wd, ra, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1), 16'($urandom));
    end
    cyc(0, 0, 0, S, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
